// File: rtl/clint_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clint_pkg : register map bases and helpers shared by clint_mc     |
// | Revision  : 1.0                                                   |
// +-------------------------------------------------------------------+
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

  function automatic int hart_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clint_tick_gen.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clint_tick_gen : mtime tick from synchronised rt_clk or prescaler |
// | Revision       : 1.0                                              |
// +-------------------------------------------------------------------+
module clint_tick_gen #(
  parameter int TICK_SRC    = 0,
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rt_clk,
  output logic tick
);

  generate
    if (TICK_SRC == 0) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_prev;
      logic [31:0]            w_unused_presc;

      assign w_unused_presc = PRESCALE;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sync <= '0;
          r_prev <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], rt_clk};
          r_prev <= r_sync[SYNC_STAGES-1];
        end
      end

      assign tick = r_sync[SYNC_STAGES-1] & ~r_prev;
    end else begin : g_presc
      localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] r_cnt;
      logic          w_unused_rt;
      logic [31:0]   w_unused_stages;

      assign w_unused_rt     = rt_clk;
      assign w_unused_stages = SYNC_STAGES;
      assign tick            = (r_cnt == LAST);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/clint_mc.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clint_mc : multi-hart CLINT (mtime, mtimecmp/mtip, msip)          |
// | Revision : 1.0                                                    |
// +-------------------------------------------------------------------+
module clint_mc
  import clint_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int N_CORES     = 1,
  parameter int TICK_SRC    = 0,
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int SNAPSHOT    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rt_clk,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic [N_CORES-1:0]  mtip,
  output logic [N_CORES-1:0]  msip
);

  localparam int HW = hart_idx_w(N_CORES);

  logic [63:0]        r_mtime;
  logic [63:0]        r_cmp [N_CORES];
  logic [N_CORES-1:0] r_msip;
  logic [N_CORES-1:0] r_mtip;
  logic [31:0]        r_shadow;

  logic [15:0]       w_addr;
  logic [15:0]       w_cmp_off;
  logic [11:0]       w_msip_h;
  logic [12:0]       w_cmp_h;
  logic [HW-1:0]     w_msip_idx;
  logic [HW-1:0]     w_cmp_idx;
  logic              w_msip_sel;
  logic              w_cmp_sel;
  logic              w_mtime_lo;
  logic              w_mtime_hi;
  logic              w_write;
  logic              w_wr;
  logic              w_rd_lo;
  logic              w_tick;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_unused_bits;

  clint_tick_gen #(
    .TICK_SRC    (TICK_SRC),
    .PRESCALE    (PRESCALE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .rt_clk (rt_clk),
    .tick   (w_tick)
  );

  // Only address[15:2] selects a register; the rest is deliberately ignored.
  assign w_addr        = address[15:0];
  assign w_cmp_off     = w_addr - MTIMECMP_BASE;
  assign w_msip_h      = w_addr[13:2];
  assign w_cmp_h       = w_cmp_off[15:3];
  assign w_msip_idx    = w_msip_h[HW-1:0];
  assign w_cmp_idx     = w_cmp_h[HW-1:0];
  assign w_unused_bits = ^{address[ADDR_W-1:16], w_addr[1:0], w_cmp_off[2:0]};

  assign w_msip_sel = (w_addr[15:14] == MSIP_BASE[15:14]) &&
                      ({20'd0, w_msip_h} < 32'(N_CORES));
  assign w_cmp_sel  = (w_addr >= MTIMECMP_BASE) && (w_addr < MTIME_BASE) &&
                      ({19'd0, w_cmp_h} < 32'(N_CORES));
  assign w_mtime_lo = (w_addr[15:2] == MTIME_BASE[15:2]);
  assign w_mtime_hi = (w_addr[15:2] == MTIME_BASE[15:2] + 14'd1);

  assign w_write = |wstrb;
  assign w_wr    = valid & w_write;
  assign w_rd_lo = valid & ~w_write & w_mtime_lo;

  always_comb begin
    w_rd_val = '0;
    if (w_msip_sel) begin
      w_rd_val = {31'd0, r_msip[w_msip_idx]};
    end else if (w_cmp_sel) begin
      w_rd_val = w_addr[2] ? r_cmp[w_cmp_idx][63:32] : r_cmp[w_cmp_idx][31:0];
    end else if (w_mtime_lo) begin
      w_rd_val = r_mtime[31:0];
    end else if (w_mtime_hi) begin
      w_rd_val = (SNAPSHOT != 0) ? r_shadow : r_mtime[63:32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready    <= 1'b0;
      rdata    <= '0;
      r_shadow <= '0;
    end else begin
      ready <= valid;
      if (valid) begin
        rdata <= w_write ? '0 : w_rd_val;
      end
      if (w_rd_lo) begin
        r_shadow <= r_mtime[63:32];
      end
    end
  end

  // A bus write to mtime takes priority over a coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtime <= '0;
    end else if (w_wr && w_mtime_lo) begin
      r_mtime <= {r_mtime[63:32], merge_bytes(r_mtime[31:0], wdata, wstrb)};
    end else if (w_wr && w_mtime_hi) begin
      r_mtime <= {merge_bytes(r_mtime[63:32], wdata, wstrb), r_mtime[31:0]};
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CORES; i++) begin
        r_cmp[i] <= '1;
      end
    end else if (w_wr && w_cmp_sel) begin
      if (w_addr[2]) begin
        r_cmp[w_cmp_idx][63:32] <= merge_bytes(r_cmp[w_cmp_idx][63:32], wdata, wstrb);
      end else begin
        r_cmp[w_cmp_idx][31:0] <= merge_bytes(r_cmp[w_cmp_idx][31:0], wdata, wstrb);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_msip <= '0;
    end else if (w_wr && w_msip_sel && wstrb[0]) begin
      r_msip[w_msip_idx] <= wdata[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtip <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        r_mtip[i] <= (r_mtime >= r_cmp[i]);
      end
    end
  end

  assign mtip = r_mtip;
  assign msip = r_msip;

endmodule
`default_nettype wire

// File: tb/tb_clint_mc.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_clint_mc : directed + random bench for clint_mc, 3 harts       |
// | Revision    : 1.0                                                 |
// +-------------------------------------------------------------------+
module tb_clint_mc;

  localparam int NC = 3;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          rt_clk  = 1'b0;
  logic          valid   = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   wdata   = '0;
  logic [3:0]    wstrb   = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic [NC-1:0] mtip;
  logic [NC-1:0] msip;

  int checks   = 0;
  int failures = 0;

  clint_mc #(
    .ADDR_W(32), .DATA_W(32), .N_CORES(NC), .TICK_SRC(1),
    .PRESCALE(4), .SYNC_STAGES(2), .SNAPSHOT(1)
  ) dut (
    .clk(clk), .reset(reset), .rt_clk(rt_clk), .valid(valid),
    .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .mtip(mtip), .msip(msip)
  );

  always #5 clk = ~clk;

  // Reference state: one tick every fourth clock edge after reset release.
  logic [63:0]   m_time;
  logic [63:0]   m_cmp [NC];
  logic [NC-1:0] m_msip;
  logic [NC-1:0] m_mtip;
  logic [31:0]   m_shadow;
  logic [31:0]   m_rdata;
  logic          m_ready;
  int            n_edges;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_time = '0; m_msip = '0; m_mtip = '0; m_shadow = '0;
    m_rdata = '0; m_ready = 1'b0; n_edges = 0;
    for (int h = 0; h < NC; h++) m_cmp[h] = '1;
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] a);
    int h;
    if (a < 16'h4000) begin
      h = int'(a) / 4;
      return (h < NC) ? {31'd0, m_msip[h]} : 32'd0;
    end else if (a < 16'hBFF8) begin
      h = (int'(a) - 'h4000) / 8;
      if (h < NC) return a[2] ? m_cmp[h][63:32] : m_cmp[h][31:0];
      return 32'd0;
    end else if (a[15:2] == 14'h2FFE) begin
      return m_time[31:0];
    end else if (a[15:2] == 14'h2FFF) begin
      return m_shadow;
    end
    return 32'd0;
  endfunction

  task automatic model_edge(input bit v, input logic [31:0] ad, input logic [31:0] wd,
                            input logic [3:0] ws);
    logic [15:0] a;
    logic [63:0] t0;
    bit          tick;
    bit          tw;
    int          h;
    a    = ad[15:0];
    t0   = m_time;
    tick = (n_edges % 4 == 3);
    tw   = 1'b0;
    for (int i = 0; i < NC; i++) m_mtip[i] = (t0 >= m_cmp[i]);
    m_ready = v;
    if (v && ws == 4'd0) begin
      m_rdata = m_read(a);
      if (a[15:2] == 14'h2FFE) m_shadow = t0[63:32];
    end else if (v) begin
      m_rdata = '0;
      if (a < 16'h4000) begin
        h = int'(a) / 4;
        if (h < NC && ws[0]) m_msip[h] = wd[0];
      end else if (a < 16'hBFF8) begin
        h = (int'(a) - 'h4000) / 8;
        if (h < NC) begin
          if (a[2]) m_cmp[h][63:32] = bmerge(m_cmp[h][63:32], wd, ws);
          else      m_cmp[h][31:0]  = bmerge(m_cmp[h][31:0], wd, ws);
        end
      end else if (a[15:2] == 14'h2FFE) begin
        m_time[31:0] = bmerge(m_time[31:0], wd, ws); tw = 1'b1;
      end else if (a[15:2] == 14'h2FFF) begin
        m_time[63:32] = bmerge(m_time[63:32], wd, ws); tw = 1'b1;
      end
    end
    if (!tw && tick) m_time = m_time + 64'd1;
    n_edges++;
  endtask

  // Drives one request (or idle), advances one edge, then checks all outputs.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws);
    valid = v; address = a; wdata = wd; wstrb = ws;
    @(posedge clk);
    model_edge(v, a, wd, ws);
    #1;
    valid = 1'b0;
    check("ready", {63'd0, ready}, {63'd0, m_ready});
    if (m_ready) check("rdata", {32'd0, rdata}, {32'd0, m_rdata});
    check("mtip", {61'd0, mtip}, {61'd0, m_mtip});
    check("msip", {61'd0, msip}, {61'd0, m_msip});
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b1, a, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cycle(1'b1, a, d, s);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    valid = 1'b0;
    #1;
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_mtip", {61'd0, mtip}, 64'd0);
    check("rst_msip", {61'd0, msip}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic align(input int phase);
    while (n_edges % 4 != phase) idle();
  endtask

  initial begin
    logic [31:0]  r;
    logic [31:0]  a;
    logic [15:0]  base;
    logic [15:0]  bases [16];
    bases = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h4000, 16'h4004, 16'h4008,
              16'h400C, 16'h4010, 16'h4014, 16'h4018, 16'hBFF8, 16'hBFFC, 16'h1234,
              16'hBFF4, 16'hC000};
    #2;
    do_reset();

    rd(32'h4000); check("cmp0_lo_rst", {32'd0, rdata}, 64'hFFFF_FFFF);
    rd(32'h4004); check("cmp0_hi_rst", {32'd0, rdata}, 64'hFFFF_FFFF);
    rd(32'hBFF8); check("mtime_lo_rst", {32'd0, rdata}, 64'd0);
    rd(32'h0000); check("msip0_rst", {32'd0, rdata}, 64'd0);
    idle();       check("ready_one_cycle", {63'd0, ready}, 64'd0);

    wr(32'h0008, 32'd1, 4'b0001);
    check("msip2_set", {61'd0, msip}, 64'b100);
    rd(32'h000C);
    check("msip_h3_rdata", {32'd0, rdata}, 64'd0);
    check("msip_h3_ready", {63'd0, ready}, 64'd1);
    check("msip_h3_keep", {61'd0, msip}, 64'b100);

    do_reset();
    wr(32'h4004, 32'd0, 4'hF);
    wr(32'h4000, 32'd10, 4'hF);
    while (n_edges < 40) idle();
    check("mtip0_before", {63'd0, mtip[0]}, 64'd0);
    idle();
    check("mtip0_rise", {63'd0, mtip[0]}, 64'd1);

    wr(32'h4000, 32'hFFFF_FFFF, 4'hF);
    wr(32'h4000, 32'h1122_3344, 4'b0101);
    rd(32'h4000); check("byte_merge", {32'd0, rdata}, 64'hFF22_FF44);

    align(1);
    wr(32'hBFFC, 32'd0, 4'hF);
    wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    rd(32'hBFF8); check("snap_lo", {32'd0, rdata}, 64'hFFFF_FFFF);
    rd(32'hBFFC); check("snap_hi_shadow", {32'd0, rdata}, 64'd0);
    rd(32'hBFF8); check("carry_lo", {32'd0, rdata}, 64'd0);
    rd(32'hBFFC); check("carry_hi", {32'd0, rdata}, 64'd1);

    wr(32'h4010, 32'd0, 4'hF);
    wr(32'h4014, 32'd0, 4'hF);
    align(1);
    wr(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    idle(); check("mtip_all_ones", {61'd0, mtip}, 64'b111);
    rd(32'hBFF8); check("wrap_lo", {32'd0, rdata}, 64'd0);
    check("mtip_after_wrap", {61'd0, mtip}, 64'b100);
    align(3);
    wr(32'hBFF8, 32'h1234_5678, 4'hF);
    rd(32'hBFF8); check("tick_collision", {32'd0, rdata}, 64'h1234_5678);

    rd(32'h4000);
    do_reset();
    rd(32'h4010); check("cmp2_after_reset", {32'd0, rdata}, 64'hFFFF_FFFF);

    for (int i = 0; i < 300; i++) begin
      r    = $urandom();
      base = bases[$urandom_range(0, 15)];
      a    = {r[31:16], base[15:2], r[1:0]};
      wdata = $urandom();
      if ($urandom_range(0, 1) == 0) wdata = wdata & 32'h0000_000F;
      cycle(($urandom_range(0, 4) != 0), a, wdata,
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
